// File: rtl/rf_write_ctrl_pkg.sv
// Shared CPU constants for the register-file writeback path: register file
// geometry, the stack-pointer index and the write-controller state encoding.
package rf_write_ctrl_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam addr_t SP_ADDR = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    SP_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// Writeback request channel from the execute stage into the register-file
// write controller; the master issues requests, the slave applies backpressure.
interface rf_write_ctrl_if;
  import rf_write_ctrl_pkg::*;

  logic  wb_valid;
  logic  wb_ready;
  addr_t wb_dst;
  data_t wb_data;
  logic  wb_sp_upd;
  data_t wb_sp_data;

  modport master (
    output wb_valid, wb_dst, wb_data, wb_sp_upd, wb_sp_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_dst, wb_data, wb_sp_upd, wb_sp_data,
    output wb_ready
  );

endinterface

// File: rtl/rf_write_ctrl.sv
// Serialises writeback requests onto the single register-file write port;
// a request that also moves SP costs two cycles (destination first, then R3).
module rf_write_ctrl
  import rf_write_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_write_ctrl_if.slave    wb,
  input  logic              clr,
  output logic              wr_en,
  output addr_t             wr_addr,
  output data_t             wr_data,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic              sp_conflict,
  output logic [CNT_W-1:0]  wr_count
);

  state_e           state_q;
  logic             wr_en_q;
  addr_t            wr_addr_q;
  data_t            wr_data_q;
  data_t            sp_data_q;
  logic             sp_conflict_q;
  logic             sp_conflict_d;
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] wr_count_d;
  logic             accept;

  assign wb.wb_ready = (state_q == IDLE);
  assign accept      = wb.wb_valid && wb.wb_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_q <= accept;
          if (accept) begin
            wr_addr_q <= wb.wb_dst;
            wr_data_q <= wb.wb_data;
            // A request whose destination is SP itself keeps only wb_data.
            if (wb.wb_sp_upd && (wb.wb_dst != SP_ADDR)) begin
              sp_data_q <= wb.wb_sp_data;
              state_q   <= SP_PEND;
            end
          end
        end
        SP_PEND: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= SP_ADDR;
          wr_data_q <= sp_data_q;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sp_conflict_d = sp_conflict_q;
    wr_count_d    = wr_count_q;
    if (clr) begin
      sp_conflict_d = 1'b0;
      wr_count_d    = '0;
    end else begin
      if (accept && wb.wb_sp_upd && (wb.wb_dst == SP_ADDR)) begin
        sp_conflict_d = 1'b1;
      end
      if (wr_en_q && (wr_count_q != '1)) begin
        wr_count_d = wr_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_conflict_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      sp_conflict_q <= sp_conflict_d;
      wr_count_q    <= wr_count_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_mask[i] = wr_en_q && (wr_addr_q == ADDR_W'(i));
    end
    if (state_q == SP_PEND) begin
      pend_mask[SP_ADDR] = 1'b1;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign sp_conflict = sp_conflict_q;
  assign wr_count    = wr_count_q;

endmodule
